// File: rtl/mmio_uart_responder.sv
// mmio_uart_responder: memory-mapped 8N1 UART transmitter sharing CPU data port B with the BRAM.
// Define MMIO_UART_IRQ_EN to add the IRQEN register and the registered TX-empty interrupt.
module mmio_uart_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_4000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  web,
    input  logic [31:0] addrb,
    input  logic [31:0] dib,
    output logic [31:0] dob,
    output logic        sel_q,
    output logic        uart_tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d, sel_d;
    logic [15:0]   baud_q, baud_d, div_q, div_d, bcnt_q, bcnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    sh_q, sh_d;
    logic [31:0]   dob_q, dob_d, rdata;
    logic [1:0]    off;
    logic          hit, wr, full, empty, push_req, push, pop, last, irqen;
    logic          unused;
    assign hit      = addrb[31:4] == BASE_ADDR[31:4];
    assign off      = addrb[3:2];
    assign wr       = hit && |web;
    assign full     = count_q == CW'(FIFO_DEPTH);
    assign empty    = count_q == '0;
    assign push_req = wr && off == 2'd0 && web[0];
    // Fullness is judged before this cycle's pop, so a push into a full FIFO is dropped even if a pop frees a slot.
    assign push     = push_req && !full;
    assign pop      = state_q == IDLE && !empty;
    assign last     = bcnt_q == div_q - 16'd1;
    assign uart_tx  = (state_q == START) ? 1'b0 : (state_q == DATA) ? sh_q[0] : 1'b1;
    assign dob      = dob_q;
    assign unused   = ^{addrb[1:0], dib[31:16]};
`ifdef MMIO_UART_IRQ_EN
    logic irqen_q, irqen_d, irq_q, irq_d;
    assign irqen = irqen_q;
    assign irq   = irq_q;
    always_comb begin
        irqen_d = (wr && off == 2'd3 && web[0]) ? dib[0] : irqen_q;
        irq_d   = irqen_q && empty && state_q == IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            irqen_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
        end
    end
`else
    assign irqen = 1'b0;
    assign irq   = 1'b0;
`endif
    always_comb begin
        rdata = '0;
        case (off)
            2'd0: rdata = '0;
            2'd1: begin
                rdata[0]       = full;
                rdata[1]       = empty;
                rdata[2]       = state_q != IDLE;
                rdata[3]       = ovf_q;
                rdata[8 +: CW] = count_q;
            end
            2'd2: rdata[15:0] = baud_q;
            default: rdata[0] = irqen;
        endcase
        dob_d = hit ? rdata : '0;
        sel_d = hit;
    end
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        baud_d = baud_q;
        if (push) begin
            mem_d[wptr_q] = dib[7:0];
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
        count_d = count_q + CW'(push) - CW'(pop);
        if (push_req && full) ovf_d = 1'b1;
        if (wr && off == 2'd1 && web[0] && dib[3]) ovf_d = 1'b0;
        if (wr && off == 2'd2 && web[0]) baud_d[7:0] = dib[7:0];
        if (wr && off == 2'd2 && web[1]) baud_d[15:8] = dib[15:8];
    end
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bidx_d  = bidx_q;
        div_d   = div_q;
        bcnt_d  = (state_q == IDLE || last) ? 16'd0 : bcnt_q + 16'd1;
        case (state_q)
            IDLE: if (!empty) begin
                state_d = START;
                sh_d    = mem_q[rptr_q];
                // Divisor is frozen per frame so BAUDDIV writes only affect the next frame.
                div_d   = (baud_q == 16'd0) ? 16'd1 : baud_q;
            end
            START: if (last) begin
                state_d = DATA;
                bidx_d  = 3'd0;
            end
            DATA: if (last) begin
                sh_d    = sh_q >> 1;
                bidx_d  = bidx_q + 3'd1;
                state_d = (bidx_q == 3'd7) ? STOP : DATA;
            end
            default: if (last) state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) mem_q <= mem_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            baud_q  <= 16'(CLKS_PER_BIT);
            div_q   <= 16'd1;
            bcnt_q  <= 16'd0;
            bidx_q  <= 3'd0;
            sh_q    <= 8'd0;
            dob_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            baud_q  <= baud_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
            bidx_q  <= bidx_d;
            sh_q    <= sh_d;
            dob_q   <= dob_d;
            sel_q   <= sel_d;
        end
    end
endmodule

// File: tb/tb_mmio_uart_responder.sv
// tb_mmio_uart_responder: register table, directed frame/overflow/reset sequences and random traffic
// checked every cycle against a queue-and-timeline model of the UART.
module tb_mmio_uart_responder;
    logic        clk = 1'b0, rst = 1'b1, sel_q, uart_tx, irq;
    logic [3:0]  web = '0;
    logic [31:0] addrb = '0, dib = '0, dob, v;
    int          total = 0, bad = 0;
    always #5 clk = ~clk;
    mmio_uart_responder dut (.clk(clk), .rst(rst), .web(web), .addrb(addrb), .dib(dib),
                             .dob(dob), .sel_q(sel_q), .uart_tx(uart_tx), .irq(irq));
    // Model: pending bytes in a queue; the frame in flight is described by its pop cycle, byte and divisor.
    logic [7:0]  q[$];
    logic [7:0]  fb = '0;
    logic        m_ovf = 1'b0, m_irqen = 1'b0, e_sel = 1'b0, e_irq = 1'b0;
    logic [15:0] m_baud = 16'd868;
    logic [31:0] e_dob = '0;
    longint      cyc = 0, free_at = 0, fs = 0;
    int          fdiv = 1;
    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
        end
    endtask
    function automatic logic m_tx();
        longint k;
        if (cyc > fs && cyc < free_at) begin
            k = (cyc - fs - 1) / fdiv;
            if (k == 0) return 1'b0;
            if (k <= 8) return fb[int'(k - 1)];
        end
        return 1'b1;
    endfunction
    task automatic step();
        logic        h, busy, full;
        logic [1:0]  o;
        logic [31:0] rv;
        h    = addrb[31:4] == 28'h0000400;
        o    = addrb[3:2];
        busy = cyc < free_at;
        full = q.size() == 8;
        rv   = (o == 2'd1) ? {16'b0, 8'(q.size()), 4'b0, m_ovf, busy, q.size() == 0, full} :
               (o == 2'd2) ? {16'b0, m_baud} : (o == 2'd3) ? {31'b0, m_irqen} : 32'b0;
        if (rst) begin
            e_dob = '0; e_sel = 1'b0; e_irq = 1'b0;
            q.delete(); m_ovf = 1'b0; m_baud = 16'd868; m_irqen = 1'b0; free_at = 0;
        end else begin
            e_dob = h ? rv : '0;
            e_sel = h;
            e_irq = m_irqen && q.size() == 0 && !busy;
            if (!busy && q.size() > 0) begin
                fb = q.pop_front();
                fs = cyc;
                fdiv = (m_baud == 0) ? 1 : int'(m_baud);
                free_at = cyc + 10 * fdiv + 1;
            end
            if (h && web != 0) begin
                if (o == 2'd0 && web[0]) begin
                    if (full) m_ovf = 1'b1;
                    else q.push_back(dib[7:0]);
                end
                if (o == 2'd1 && web[0] && dib[3]) m_ovf = 1'b0;
                if (o == 2'd2 && web[0]) m_baud[7:0] = dib[7:0];
                if (o == 2'd2 && web[1]) m_baud[15:8] = dib[15:8];
`ifdef MMIO_UART_IRQ_EN
                if (o == 2'd3 && web[0]) m_irqen = dib[0];
`endif
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("uart_tx", uart_tx, m_tx());
        check("dob", dob, e_dob);
        check("sel_q", sel_q, e_sel);
        check("irq", irq, e_irq);
    endtask
    task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        addrb = a; web = w; dib = d;
        step();
        addrb = '0; web = '0; dib = '0;
    endtask
    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        addrb = a; web = '0;
        step();
        r = dob;
        addrb = '0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask
    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  web;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
        logic        esel;
    } vec_t;
    vec_t tbl[13];
    initial begin
        logic [9:0] fr;
        logic       all_busy;
        logic [31:0] irq_exp;
`ifdef MMIO_UART_IRQ_EN
        irq_exp = 32'd1;
`else
        irq_exp = 32'd0;
`endif
        tbl[0]  = '{32'h0,    4'h0, 32'h0,         32'h4004, 32'h2,      1'b1};
        tbl[1]  = '{32'h4008, 4'h3, 32'h4,         32'h4008, 32'h4,      1'b1};
        tbl[2]  = '{32'h4008, 4'h1, 32'hFFFF_FF10, 32'h4008, 32'h10,     1'b1};
        tbl[3]  = '{32'h4008, 4'h2, 32'h0000_AB00, 32'h4008, 32'hAB10,   1'b1};
        tbl[4]  = '{32'h4008, 4'hC, 32'hFFFF_0000, 32'h4008, 32'hAB10,   1'b1};
        tbl[5]  = '{32'h4008, 4'h0, 32'h1234,      32'h4008, 32'hAB10,   1'b1};
        tbl[6]  = '{32'h4018, 4'hF, 32'h55,        32'h4008, 32'hAB10,   1'b1};
        tbl[7]  = '{32'h4004, 4'h1, 32'h8,         32'h4004, 32'h2,      1'b1};
        tbl[8]  = '{32'h400C, 4'h1, 32'h1,         32'h400C, irq_exp,    1'b1};
        tbl[9]  = '{32'h400C, 4'h1, 32'h0,         32'h400C, 32'h0,      1'b1};
        tbl[10] = '{32'h0,    4'h0, 32'h0,         32'h3FFC, 32'h0,      1'b0};
        tbl[11] = '{32'h4008, 4'h3, 32'h0,         32'h4010, 32'h0,      1'b0};
        tbl[12] = '{32'h0,    4'h0, 32'h0,         32'h4008, 32'h0,      1'b1};
        do_reset();
        check("reset_tx", uart_tx, 1'b1);
        check("reset_sel", sel_q, 1'b0);
        check("reset_dob", dob, 32'h0);
        check("reset_irq", irq, 1'b0);
        rd(32'h4004, v);
        check("reset_status", v, 32'h2);
        rd(32'h4008, v);
        check("reset_baud", v, 32'd868);
        for (int i = 0; i < 13; i++) begin
            wr(tbl[i].waddr, tbl[i].web, tbl[i].wdata);
            rd(tbl[i].raddr, v);
            check($sformatf("tbl%0d_dob", i), v, tbl[i].exp);
            check($sformatf("tbl%0d_sel", i), sel_q, tbl[i].esel);
        end
        // One 0xA5 frame at div 4 while STATUS is read continuously.
        wr(32'h4008, 4'h3, 32'd4);
        wr(32'h4000, 4'h1, 32'hA5);
        fr = {1'b1, 8'hA5, 1'b0};
        all_busy = 1'b1;
        addrb = 32'h4004;
        for (int i = 1; i <= 41; i++) begin
            step();
            check($sformatf("frame_a5_%0d", i), uart_tx, (i <= 40) ? fr[(i - 1) / 4] : 1'b1);
            if (i >= 2 && !dob[2]) all_busy = 1'b0;
        end
        addrb = '0;
        check("frame_busy", all_busy, 1'b1);
        rd(32'h4004, v);
        check("frame_done_status", v, 32'h2);
        // Overflow at div 1000.
        wr(32'h4008, 4'h3, 32'd1000);
        addrb = 32'h4000; web = 4'h1;
        for (int i = 0; i < 9; i++) begin
            dib = 32'h10 + i;
            step();
        end
        addrb = '0; web = '0; dib = '0;
        rd(32'h4004, v);
        check("full_status", v, 32'h805);
        wr(32'h4000, 4'h1, 32'hEE);
        rd(32'h4004, v);
        check("ovf_status", v, 32'h80D);
        wr(32'h4004, 4'h1, 32'h8);
        rd(32'h4004, v);
        check("ovf_clear", v, 32'h805);
        do_reset();
        check("abort_tx", uart_tx, 1'b1);
        // Misses and a lane-1 store to TXDATA must not push.
        wr(32'h3FFC, 4'hF, 32'h11);
        check("miss_low_sel", sel_q, 1'b0);
        wr(32'h4010, 4'hF, 32'h22);
        check("miss_high_sel", sel_q, 1'b0);
        wr(32'h4000, 4'h2, 32'h3300);
        rd(32'h4004, v);
        check("no_push_status", v, 32'h2);
        repeat (5) step();
        // Reset in the middle of DATA with three bytes still queued.
        wr(32'h4008, 4'h3, 32'd4);
        addrb = 32'h4000; web = 4'h1;
        for (int i = 0; i < 4; i++) begin
            dib = 32'hC0 + i;
            step();
        end
        addrb = '0; web = '0; dib = '0;
        repeat (10) step();
        do_reset();
        check("mid_data_reset_tx", uart_tx, 1'b1);
        rd(32'h4004, v);
        check("mid_data_reset_status", v, 32'h2);
        rd(32'h4008, v);
        check("mid_data_reset_baud", v, 32'd868);
`ifdef MMIO_UART_IRQ_EN
        wr(32'h4008, 4'h3, 32'd2);
        wr(32'h400C, 4'h1, 32'h1);
        repeat (2) step();
        check("irq_idle", irq, 1'b1);
        wr(32'h4000, 4'h1, 32'h3C);
        repeat (3) step();
        check("irq_busy", irq, 1'b0);
        repeat (25) step();
        check("irq_after_stop", irq, 1'b1);
        wr(32'h4000, 4'h1, 32'h3D);
        step();
        check("irq_after_push", irq, 1'b0);
        repeat (30) step();
`endif
        // Random traffic, including BAUDDIV=0, overflow, clears and occasional resets.
        do_reset();
        wr(32'h4008, 4'h3, 32'($urandom_range(0, 3)));
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
                wr(32'h4008, 4'h3, 32'($urandom_range(0, 3)));
            end else if (r < 60) begin
                addrb = 32'h4000; web = 4'($urandom_range(1, 15)); dib = $urandom;
                step();
            end else if (r < 80) begin
                addrb = 32'h3FF0 + 4 * $urandom_range(0, 11); web = '0;
                step();
            end else if (r < 88) begin
                addrb = 32'h4004; web = 4'($urandom_range(0, 15)); dib = $urandom;
                step();
            end else if (r < 91) begin
                addrb = 32'h4008; web = 4'($urandom_range(0, 3)); dib = 32'($urandom_range(0, 3));
                step();
            end else begin
                step();
            end
            addrb = '0; web = '0; dib = '0;
        end
        wr(32'h4008, 4'h3, 32'd1);
        for (int i = 0; i < 2000 && (q.size() > 0 || cyc < free_at); i++) step();
        rd(32'h4004, v);
        check("drain_status", v[2:0], 3'b010);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
